// File: rtl/vga_line_fetch_arb.sv
// VGA line fetch and single-port memory arbiter.
// Ping-pong line buffer filled from pixel memory; writer gets idle slots.
module vga_line_fetch_arb #(
    parameter int H_VISIBLE = 800,
    parameter int V_VISIBLE = 480,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic [9:0]        line_num,
    input  logic [9:0]        pix_h,
    output logic [DATA_W-1:0] pix_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              underrun,
    input  logic              clr_underrun
);

    localparam int IW = 10;
    localparam int LW = $clog2(2 * H_VISIBLE);

    localparam logic [IW-1:0]     IDX_LAST = IW'(H_VISIBLE - 1);
    localparam logic [ADDR_W-1:0] H_STEP   = ADDR_W'(H_VISIBLE);
    localparam logic [IW:0]       V_END    = (IW + 1)'(V_VISIBLE);
    localparam logic [LW-1:0]     HALF_OFS = LW'(H_VISIBLE);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                dsel_q, dsel_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rd_pend_q;
    logic                rd_half_q;
    logic [IW-1:0]       rd_idx_q;
    logic                rd_issue;
    logic                wr_acc;
    logic                start_evt;
    logic                ovl_evt;
    logic [IW:0]         next_line;
    logic [LW-1:0]       fill_ix;
    logic [LW-1:0]       disp_ix;
    logic                pix_ok;

    logic [DATA_W-1:0]   lbuf [2*H_VISIBLE];

    assign start_evt = frame_start | line_start;
    assign ovl_evt   = start_evt && (state_q != IDLE);
    assign next_line = {1'b0, line_num} + {{IW{1'b0}}, 1'b1};

    // Next-state logic: start pulses restart the fetch, otherwise walk the line.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        base_d   = base_q;
        dsel_d   = dsel_q;
        rd_issue = 1'b0;
        if (frame_start) begin
            state_d = FETCH;
            idx_d   = '0;
            base_d  = '0;
        end else if (line_start) begin
            state_d = FETCH;
            idx_d   = '0;
            dsel_d  = ~dsel_q;
            if (next_line == V_END) begin
                base_d = '0;
            end else begin
                base_d = base_q + H_STEP;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                FETCH: begin
                    rd_issue = 1'b1;
                    idx_d    = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = DRAIN;
                        idx_d   = '0;
                    end
                end
                DRAIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Memory port arbitration: fetch reads first, writer takes the rest.
    always_comb begin
        wr_gnt    = ~reset && (state_q != FETCH) && ~line_start && ~frame_start;
        wr_acc    = wr_req && wr_gnt;
        mem_re    = rd_issue;
        mem_we    = wr_acc;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (rd_issue) begin
            mem_addr = base_q + {{(ADDR_W-IW){1'b0}}, idx_q};
        end else if (wr_acc) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end
    end

    assign busy = (state_q == FETCH) || (state_q == DRAIN);

    // Control state, held port values and in-flight read tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            base_q    <= '0;
            dsel_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_half_q <= 1'b0;
            rd_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            dsel_q    <= dsel_d;
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
            rd_pend_q <= rd_issue;
            if (rd_issue) begin
                rd_half_q <= ~dsel_q;
                rd_idx_q  <= idx_q;
            end
        end
    end

    // Sticky deadline-miss flag; a new miss beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (ovl_evt) begin
            underrun <= 1'b1;
        end else if (clr_underrun) begin
            underrun <= 1'b0;
        end
    end

    assign fill_ix = rd_half_q ? (HALF_OFS + LW'(rd_idx_q)) : LW'(rd_idx_q);
    assign disp_ix = dsel_q ? (HALF_OFS + LW'(pix_h)) : LW'(pix_h);
    assign pix_ok  = (32'(pix_h) < H_VISIBLE);

    // Capture returning read data into the half/index it was issued for.
    always_ff @(posedge clk) begin
        if (rd_pend_q && !reset) begin
            lbuf[fill_ix] <= mem_rdata;
        end
    end

    // Registered display read from the display half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_data <= '0;
        end else if (pix_ok) begin
            pix_data <= lbuf[disp_ix];
        end else begin
            pix_data <= '0;
        end
    end

endmodule

// File: doc/vga_line_fetch_arb.md
VGA_LINE_FETCH_ARB -- requirements
Module: vga_line_fetch_arb

Interface
REQ-001 Parameters SHALL be:
- H_VISIBLE, 800, pixels per visible line.
- V_VISIBLE, 480, visible lines per frame.
- ADDR_W, 19, pixel-memory address width.
- DATA_W, 16, pixel width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, pixel clock; all state on rising edge.
- reset, in, 1, reset, asynchronous, active-high.
- frame_start, in, 1, one-cycle pulse before the first visible line of a frame.
- line_start, in, 1, one-cycle pulse when visible line line_num begins.
- line_num, in, 10, visible line index; valid with line_start.
- pix_h, in, 10, pixel index to display (0..H_VISIBLE-1).
- pix_data, out, DATA_W, display-half line-buffer word for pix_h; 1-cycle latency.
- wr_req, in, 1, writer requests one pixel write.
- wr_addr, in, ADDR_W, writer address.
- wr_data, in, DATA_W, writer data.
- wr_gnt, out, 1, combinational; write accepted in any cycle where wr_req and wr_gnt are both high.
- mem_re, out, 1, single-port memory read strobe.
- mem_we, out, 1, single-port memory write strobe.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, read data, valid exactly 1 cycle after mem_re.
- busy, out, 1, high while a fetch is in FETCH or DRAIN.
- underrun, out, 1, sticky fetch-deadline miss flag.
- clr_underrun, in, 1, synchronous clear of underrun.

Function
REQ-003 The block SHALL hold a 2*H_VISIBLE-word ping-pong line buffer; dsel selects the display half, !dsel the fetch half.
REQ-004 FSM states SHALL be IDLE, FETCH and DRAIN.
REQ-005 frame_start SHALL clear base to 0, leave dsel unchanged, and start a fetch of line 0 into the !dsel half (enter FETCH, idx=0).
REQ-006 line_start SHALL toggle dsel and start a fetch of line_num+1 into the new !dsel half:
- base += H_VISIBLE.
- If line_num+1 == V_VISIBLE: base = 0, so line 0 is prefetched.
REQ-007 base SHALL be updated by addition only; no multiplier.
REQ-008 In FETCH, each cycle SHALL:
- assert mem_re with mem_addr = base + idx;
- increment idx;
- on idx == H_VISIBLE-1, move to DRAIN.
REQ-009 mem_rdata SHALL be written to the fetch half at the index issued one cycle earlier.
REQ-010 DRAIN SHALL last exactly one cycle (captures the last word), then go to IDLE.
REQ-011 Fetch SHALL have priority: wr_gnt = !(state == FETCH) && !line_start && !frame_start.
REQ-012 On an accepted write, mem_we=1, mem_addr=wr_addr and mem_wdata=wr_data in the same cycle.
REQ-013 mem_re and mem_we SHALL never be high in the same cycle.
REQ-014 When no access occurs, mem_re=0, mem_we=0, and mem_addr/mem_wdata hold their last values.
REQ-015 line_start or frame_start arriving while in FETCH or DRAIN SHALL:
- set underrun;
- abort the current fetch (a pending in-flight word is still written to its old half/index);
- start the new fetch as in REQ-005/006.
REQ-016 If frame_start and line_start coincide, frame_start SHALL win and line_start is ignored.
REQ-017 pix_data SHALL be registered: buffer[dsel half][pix_h] appears the cycle after pix_h is presented.
REQ-018 clr_underrun SHALL clear underrun, except when a set event occurs in the same cycle, in which case set wins.
REQ-019 A fetch (800 cycles + 1 drain) SHALL fit in a 975-cycle line, leaving at least 174 write-grant cycles per line.

Reset
REQ-020 While reset is high, the block SHALL be in the following state:
- state=IDLE, idx=0, base=0, dsel=0;
- pix_data=0, wr_gnt=0 (reset is treated as blocking), mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0;
- busy=0, underrun=0.
REQ-021 After reset deasserts, the block SHALL stay in IDLE (wr_gnt follows REQ-011) until frame_start or line_start.
REQ-022 Reset asserted mid-fetch SHALL abandon the fetch immediately, and the in-flight read SHALL be discarded.
REQ-023 Line-buffer contents SHALL NOT be reset.

Verification
REQ-024 Pulse frame_start with memory word k = k -> mem_re high for 800 consecutive cycles, addresses 0..799; busy high for 801 cycles; buffer half 1 holds 0..799.
REQ-025 Then pulse line_start with line_num=0 and sweep pix_h 0..799 -> pix_data = 0..799 one cycle later; fetch addresses 800..1599; dsel=1.
REQ-026 Hold wr_req=1 throughout one line (wr_addr=5, wr_data=0xABCD) -> wr_gnt low during all 800 FETCH cycles and high otherwise; no cycle with mem_re and mem_we both high; memory[5]=0xABCD.
REQ-027 line_start with line_num=479 -> fetch addresses 0..799 (wrap); base=0.
REQ-028 Second line_start 400 cycles after the first -> underrun=1; fetch restarts at idx 0 with the new base. clr_underrun pulsed in the same cycle as a further overlap -> underrun stays 1.
REQ-029 Assert reset at FETCH idx=300 -> all outputs 0 the same cycle; after release, no mem_re until the next frame_start.
